// File: rtl/aes_blk_packer.sv
// Packs Ratio DataWidth-bit words into one AES block behind a valid/ack output register.
// Optional build macro AES_PACKER_BSWAP_EN byte-reverses each input word before packing.
module aes_blk_packer #(
    parameter int DataWidth = 32,
    parameter int Ratio     = 4
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst,
    input  logic [DataWidth-1:0]           data_in,
    input  logic                           last_in,
    input  logic                           vld_in,
    output logic                           ack_in,
    output logic [DataWidth*Ratio-1:0]     data_out,
    output logic                           last_out,
    output logic [Ratio-1:0]               keep_out,
    output logic                           vld_out,
    input  logic                           ack_out,
    output logic                           busy
);

    localparam int BW = DataWidth * Ratio;
    localparam int CW = $clog2(Ratio);
    localparam int NB = DataWidth / 8;
    localparam logic [CW-1:0] LastSlot = CW'(Ratio - 1);

    logic [BW-1:0]        r_acc;
    logic [Ratio-1:0]     r_acc_keep;
    logic                 r_acc_last;
    logic [CW-1:0]        r_cnt;
    logic                 r_pend;
    logic [BW-1:0]        r_dout;
    logic [Ratio-1:0]     r_keep;
    logic                 r_last;
    logic                 r_vld;

    logic [DataWidth-1:0] w_word;
    logic [BW-1:0]        w_merged;
    logic [Ratio-1:0]     w_merged_keep;
    logic                 w_out_free;
    logic                 w_xfer;
    logic                 w_close;

    always_comb begin
`ifdef AES_PACKER_BSWAP_EN
        w_word = '0;
        for (int b = 0; b < NB; b++) begin
            w_word[(NB-1-b)*8 +: 8] = data_in[b*8 +: 8];
        end
`else
        w_word = data_in;
`endif
    end

    // Accumulator contents with the incoming word dropped into slot r_cnt.
    always_comb begin
        w_merged      = r_acc;
        w_merged_keep = r_acc_keep;
        for (int k = 0; k < Ratio; k++) begin
            if (r_cnt == CW'(k)) begin
                w_merged[k*DataWidth +: DataWidth] = w_word;
                w_merged_keep[k]                   = 1'b1;
            end
        end
    end

    assign ack_in     = ~r_pend & ~ap_rst;
    assign w_out_free = ~r_vld | ack_out;
    assign w_xfer     = vld_in & ack_in;
    assign w_close    = (r_cnt == LastSlot) | last_in;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_acc      <= '0;
            r_acc_keep <= '0;
            r_acc_last <= 1'b0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_dout     <= '0;
            r_keep     <= '0;
            r_last     <= 1'b0;
            r_vld      <= 1'b0;
        end else begin
            if (r_vld & ack_out) begin
                r_vld <= 1'b0;
            end
            if (r_pend) begin
                // Parked block moves out as soon as the output register frees up.
                if (w_out_free) begin
                    r_dout     <= r_acc;
                    r_keep     <= r_acc_keep;
                    r_last     <= r_acc_last;
                    r_vld      <= 1'b1;
                    r_acc      <= '0;
                    r_acc_keep <= '0;
                    r_acc_last <= 1'b0;
                    r_cnt      <= '0;
                    r_pend     <= 1'b0;
                end
            end else if (w_xfer) begin
                if (w_close && w_out_free) begin
                    r_dout     <= w_merged;
                    r_keep     <= w_merged_keep;
                    r_last     <= last_in;
                    r_vld      <= 1'b1;
                    r_acc      <= '0;
                    r_acc_keep <= '0;
                    r_acc_last <= 1'b0;
                    r_cnt      <= '0;
                end else if (w_close) begin
                    r_acc      <= w_merged;
                    r_acc_keep <= w_merged_keep;
                    r_acc_last <= last_in;
                    r_pend     <= 1'b1;
                end else begin
                    r_acc      <= w_merged;
                    r_acc_keep <= w_merged_keep;
                    r_cnt      <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign data_out = r_dout;
    assign keep_out = r_keep;
    assign last_out = r_last;
    assign vld_out  = r_vld;
    assign busy     = (r_cnt != '0) | r_pend | r_vld;

endmodule

// File: tb/tb_aes_blk_packer.sv
// Directed bench for aes_blk_packer (DataWidth=32, Ratio=4): vector table plus streaming and reset sequences.
module tb_aes_blk_packer;

    logic         ap_clk;
    logic         ap_rst;
    logic [31:0]  data_in;
    logic         last_in;
    logic         vld_in;
    logic         ack_in;
    logic [127:0] data_out;
    logic         last_out;
    logic [3:0]   keep_out;
    logic         vld_out;
    logic         ack_out;
    logic         busy;

    aes_blk_packer #(.DataWidth(32), .Ratio(4)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .data_in  (data_in),
        .last_in  (last_in),
        .vld_in   (vld_in),
        .ack_in   (ack_in),
        .data_out (data_out),
        .last_out (last_out),
        .keep_out (keep_out),
        .vld_out  (vld_out),
        .ack_out  (ack_out),
        .busy     (busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic         vld;
        logic         last;
        logic [31:0]  din;
        logic         acko;
        logic         e_ack_in;
        logic         e_vld;
        logic [127:0] e_data;
        logic [3:0]   e_keep;
        logic         e_last;
        logic         e_busy;
    } vec_t;

    vec_t tv[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Expected block as seen on data_out: each 32-bit lane byte-reversed in the swap build.
    function automatic logic [127:0] sw(input logic [127:0] x);
        logic [127:0] y;
        y = x;
`ifdef AES_PACKER_BSWAP_EN
        for (int l = 0; l < 4; l++)
            for (int b = 0; b < 4; b++)
                y[l*32 + (3-b)*8 +: 8] = x[l*32 + b*8 +: 8];
`endif
        return y;
    endfunction

    function automatic void add(input logic v, input logic l, input logic [31:0] d, input logic a,
                                input logic eai, input logic ev, input logic [127:0] ed,
                                input logic [3:0] ek, input logic el, input logic eb);
        vec_t t;
        t.vld = v; t.last = l; t.din = d; t.acko = a;
        t.e_ack_in = eai; t.e_vld = ev; t.e_data = sw(ed);
        t.e_keep = ek; t.e_last = el; t.e_busy = eb;
        tv.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [31:0] d, input logic a);
        @(negedge ap_clk);
        vld_in = v; last_in = l; data_in = d; ack_out = a;
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        logic [127:0] exp_blk;
        int           nblk;

        ap_rst = 1'b1; vld_in = 1'b0; last_in = 1'b0; data_in = '0; ack_out = 1'b0;

        // Full block, drained immediately
        add(1,0,32'h11111111,1, 1,0,'0,4'h0,0,1);
        add(1,0,32'h22222222,1, 1,0,'0,4'h0,0,1);
        add(1,0,32'h33333333,1, 1,0,'0,4'h0,0,1);
        add(1,0,32'h44444444,1, 1,1,{32'h44444444,32'h33333333,32'h22222222,32'h11111111},4'hf,0,1);
        add(0,0,32'h0,1,        1,0,'0,4'h0,0,0);
        // Short last block
        add(1,0,32'hAAAA0001,1, 1,0,'0,4'h0,0,1);
        add(1,1,32'hAAAA0002,1, 1,1,{64'h0,32'hAAAA0002,32'hAAAA0001},4'h3,1,1);
        add(0,0,32'h0,1,        1,0,'0,4'h0,0,0);
        // Single-word messages back to back (drain and load in one cycle)
        add(1,1,32'h0000BEEF,1, 1,1,{96'h0,32'h0000BEEF},4'h1,1,1);
        add(1,1,32'h03020100,1, 1,1,{96'h0,32'h03020100},4'h1,1,1);
        add(0,0,32'h0,1,        1,0,'0,4'h0,0,0);
        // Backpressure: 8 words with ack_out low
        add(1,0,32'hB1000001,0, 1,0,'0,4'h0,0,1);
        add(1,0,32'hB1000002,0, 1,0,'0,4'h0,0,1);
        add(1,0,32'hB1000003,0, 1,0,'0,4'h0,0,1);
        add(1,0,32'hB1000004,0, 1,1,{32'hB1000004,32'hB1000003,32'hB1000002,32'hB1000001},4'hf,0,1);
        add(1,0,32'hB2000001,0, 1,1,{32'hB1000004,32'hB1000003,32'hB1000002,32'hB1000001},4'hf,0,1);
        add(1,0,32'hB2000002,0, 1,1,{32'hB1000004,32'hB1000003,32'hB1000002,32'hB1000001},4'hf,0,1);
        add(1,0,32'hB2000003,0, 1,1,{32'hB1000004,32'hB1000003,32'hB1000002,32'hB1000001},4'hf,0,1);
        add(1,0,32'hB2000004,0, 0,1,{32'hB1000004,32'hB1000003,32'hB1000002,32'hB1000001},4'hf,0,1);
        add(1,0,32'hDEADDEAD,0, 0,1,{32'hB1000004,32'hB1000003,32'hB1000002,32'hB1000001},4'hf,0,1);
        add(1,0,32'hDEADDEAD,1, 1,1,{32'hB2000004,32'hB2000003,32'hB2000002,32'hB2000001},4'hf,0,1);
        add(0,0,32'h0,1,        1,0,'0,4'h0,0,0);

        // Reset state
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst vld_out",  {127'h0, vld_out},  128'h0);
        chk("rst data_out", data_out,           128'h0);
        chk("rst keep_out", {124'h0, keep_out}, 128'h0);
        chk("rst last_out", {127'h0, last_out}, 128'h0);
        chk("rst busy",     {127'h0, busy},     128'h0);
        chk("rst ack_in",   {127'h0, ack_in},   128'h0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        chk("post-rst ack_in", {127'h0, ack_in}, 128'h1);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].vld, tv[i].last, tv[i].din, tv[i].acko);
            chk($sformatf("v%0d ack_in", i),  {127'h0, ack_in},  {127'h0, tv[i].e_ack_in});
            chk($sformatf("v%0d vld_out", i), {127'h0, vld_out}, {127'h0, tv[i].e_vld});
            chk($sformatf("v%0d busy", i),    {127'h0, busy},    {127'h0, tv[i].e_busy});
            if (tv[i].e_vld) begin
                chk($sformatf("v%0d data_out", i), data_out,           tv[i].e_data);
                chk($sformatf("v%0d keep_out", i), {124'h0, keep_out}, {124'h0, tv[i].e_keep});
                chk($sformatf("v%0d last_out", i), {127'h0, last_out}, {127'h0, tv[i].e_last});
            end
        end

        // Streaming: 64 back-to-back words, ack_out held high
        nblk = 0;
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0, 32'h50000000 + 32'(i), 1'b1);
            chk($sformatf("s%0d ack_in", i), {127'h0, ack_in}, 128'h1);
            if (i % 4 == 3) begin
                exp_blk = sw({32'h50000000 + 32'(i), 32'h50000000 + 32'(i-1),
                              32'h50000000 + 32'(i-2), 32'h50000000 + 32'(i-3)});
                chk($sformatf("s%0d vld_out", i), {127'h0, vld_out}, 128'h1);
                chk($sformatf("s%0d data_out", i), data_out, exp_blk);
                chk($sformatf("s%0d keep_out", i), {124'h0, keep_out}, 128'hf);
                if (vld_out) nblk++;
            end else begin
                chk($sformatf("s%0d vld_out", i), {127'h0, vld_out}, 128'h0);
            end
        end
        chk("stream blocks", 128'(nblk), 128'd16);
        drive(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset mid-block with a block held on the output
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 32'hC0000000 + 32'(i), 1'b0);
        chk("pre-rst vld_out", {127'h0, vld_out}, 128'h1);
        @(negedge ap_clk);
        vld_in = 1'b0;
        #2 ap_rst = 1'b1;
        #1;
        chk("async rst vld_out",  {127'h0, vld_out},  128'h0);
        chk("async rst busy",     {127'h0, busy},     128'h0);
        chk("async rst ack_in",   {127'h0, ack_in},   128'h0);
        chk("async rst data_out", data_out,           128'h0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        chk("rel ack_in", {127'h0, ack_in}, 128'h1);
        chk("rel busy",   {127'h0, busy},   128'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'hD0000000 + 32'(i), 1'b1);
            if (i < 3) chk($sformatf("r%0d vld_out", i), {127'h0, vld_out}, 128'h0);
        end
        chk("post-rst blk vld",  {127'h0, vld_out}, 128'h1);
        chk("post-rst blk data", data_out, sw({32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000}));
        chk("post-rst blk keep", {124'h0, keep_out}, 128'hf);
        chk("post-rst blk last", {127'h0, last_out}, 128'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("final busy", {127'h0, busy}, 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
